// File: rtl/muldiv_6502.sv
// 6502-bus 8x8 multiply / divide peripheral: shift-add multiply, restoring divide, 8 iterations per op.
// Optional interrupt output enabled by defining MULDIV_IRQ_EN. Read data port is rd_data ("do" is a reserved word).
module muldiv_6502 (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] di,
  output logic [7:0] rd_data,
  output logic       irq
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [W-1:0]  rd_q, rd_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d, dz_q, dz_d, op_q, op_d;

  logic          wr, rd, busy;
  logic [W-1:0]  status;
  logic [W:0]    sum, trial, diff;
  logic          ge;
  logic [W-1:0]  step_hi, step_lo;

  assign rd_data = rd_q;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      rd_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      op_q     <= 1'b0;
    end else begin
      state    <= state_next;
      a_q      <= a_d;
      b_q      <= b_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      rd_q     <= rd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      op_q     <= op_d;
    end
  end

  // Next-state, bus decode and one iteration of the selected algorithm
  always_comb begin
    state_next = state;
    a_d        = a_q;
    b_d        = b_q;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    rd_d       = rd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    dz_d       = dz_q;
    op_d       = op_q;

    wr     = cs & we;
    rd     = cs & ~we;
    busy   = (state == RUN);
    status = {busy, dz_q, done_q, 4'b0000, op_q};

    // Multiply: add multiplicand into upper half when LSB set, then shift the 17-bit pair right
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : (W+1)'(0));
    // Divide: shift next dividend bit into remainder, subtract divisor when it fits
    trial = {hi_q, lo_q[W-1]};
    diff  = trial - {1'b0, opb_q};
    ge    = (trial >= {1'b0, opb_q});
    if (op_q) begin
      step_hi = ge ? diff[W-1:0] : trial[W-1:0];
      step_lo = {lo_q[W-2:0], ge};
    end else begin
      step_hi = sum[W:1];
      step_lo = {sum[0], lo_q[W-1:1]};
    end

    if (rd) begin
      case (addr)
        3'd0:    rd_d = a_q;
        3'd1:    rd_d = b_q;
        3'd2:    rd_d = status;
        3'd3:    rd_d = res_lo_q;
        3'd4:    rd_d = res_hi_q;
        default: rd_d = '0;
      endcase
      if (addr == 3'd2) done_d = 1'b0;
    end

    case (state)
      IDLE: begin
        if (wr) begin
          case (addr)
            3'd0: a_d = di;
            3'd1: b_d = di;
            3'd2: begin
              state_next = RUN;
              op_d       = di[0];
              dz_d       = 1'b0;
              done_d     = 1'b0;
              hi_d       = '0;
              lo_d       = a_q;
              opb_d      = b_q;
              cnt_d      = '0;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CW'(1);
        // Last iteration: publish result; done wins over a coincident STATUS read
        if (cnt_q == CW'(7)) begin
          state_next = IDLE;
          res_hi_d   = step_hi;
          res_lo_d   = step_lo;
          done_d     = 1'b1;
          dz_d       = op_q & (opb_q == '0);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MULDIV_IRQ_EN
  assign irq = done_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_6502.sv
// Self-checking bench for muldiv_6502: vector table + scoreboard, plus mid-op write and mid-op reset sequences.
module tb_muldiv_6502;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] di;
  logic [7:0] rd_data;
  logic       irq;

  int tests  = 0;
  int failed = 0;
  vec_t sb[$];
  vec_t vecs[6];
  logic exp_irq_done;

  muldiv_6502 dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we),
    .addr(addr), .di(di), .rd_data(rd_data), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Each bus task is entered at a negedge and consumes exactly one rising edge
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; di = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = rd_data;
  endtask

  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic op);
    vec_t v;
    logic [15:0] p;
    v.a = a; v.b = b; v.op = op;
    if (!op) begin
      p = 16'(a) * 16'(b);
      v.lo = p[7:0]; v.hi = p[15:8]; v.st = 8'h20;
    end else if (b == 8'h00) begin
      v.lo = 8'hFF; v.hi = a; v.st = 8'h61;
    end else begin
      v.lo = a / b; v.hi = a % b; v.st = 8'h21;
    end
    return v;
  endfunction

  // Load operands, start, check busy window, then retire the scoreboard entry
  task automatic run_op(input vec_t v);
    logic [7:0] d;
    vec_t e;
    bus_write(3'd0, v.a);
    bus_write(3'd1, v.b);
    bus_write(3'd2, {7'b1010101, v.op});
    sb.push_back(v);
    for (int i = 1; i <= 8; i++) begin
      bus_read(3'd2, d);
      check($sformatf("busy_status_E%0d", i), d, {7'b1000000, v.op});
    end
    check("irq_after_E8", {7'b0, irq}, {7'b0, exp_irq_done});
    bus_read(3'd2, d);
    if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("final_status", d, e.st);
      check("irq_after_status_read", {7'b0, irq}, 8'h00);
      bus_read(3'd3, d);
      check("res_lo", d, e.lo);
      bus_read(3'd4, d);
      check("res_hi", d, e.hi);
    end
  endtask

  initial begin
    logic [7:0] d;
    vec_t v;

`ifdef MULDIV_IRQ_EN
    exp_irq_done = 1'b1;
`else
    exp_irq_done = 1'b0;
`endif

    vecs[0] = '{a:8'h0D, b:8'h0B, op:1'b0, lo:8'h8F, hi:8'h00, st:8'h20};
    vecs[1] = '{a:8'hFF, b:8'hFF, op:1'b0, lo:8'h01, hi:8'hFE, st:8'h20};
    vecs[2] = '{a:8'hC8, b:8'h07, op:1'b1, lo:8'h1C, hi:8'h04, st:8'h21};
    vecs[3] = '{a:8'h55, b:8'h00, op:1'b1, lo:8'hFF, hi:8'h55, st:8'h61};
    vecs[4] = '{a:8'h00, b:8'h37, op:1'b0, lo:8'h00, hi:8'h00, st:8'h20};
    vecs[5] = '{a:8'hFF, b:8'h01, op:1'b1, lo:8'hFF, hi:8'h00, st:8'h21};

    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; di = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("reset_do", rd_data, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);
    bus_read(3'd2, d); check("reset_status", d, 8'h00);
    bus_read(3'd3, d); check("reset_res_lo", d, 8'h00);
    bus_read(3'd4, d); check("reset_res_hi", d, 8'h00);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    for (int i = 0; i < 4; i++) begin
      v = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      run_op(v);
    end

    // Read data holds when not reading; unmapped addresses read zero
    bus_write(3'd0, 8'hA7);
    bus_read(3'd0, d); check("read_a", d, 8'hA7);
    bus_write(3'd1, 8'h3C);
    bus_write(3'd6, 8'hEE);
    @(negedge clk);
    check("do_hold", rd_data, 8'hA7);
    bus_read(3'd5, d); check("unmapped_read", d, 8'h00);
    bus_read(3'd1, d); check("read_b", d, 8'h3C);

    // Writes during RUN are ignored
    bus_write(3'd0, 8'h0D);
    bus_write(3'd1, 8'h0B);
    bus_write(3'd2, 8'h00);
    bus_read(3'd2, d); check("midwr_busy_E1", d, 8'h80);
    bus_read(3'd2, d); check("midwr_busy_E2", d, 8'h80);
    bus_write(3'd0, 8'h99);
    bus_write(3'd2, 8'h01);
    for (int i = 5; i <= 8; i++) begin
      bus_read(3'd2, d); check($sformatf("midwr_busy_E%0d", i), d, 8'h80);
    end
    bus_read(3'd2, d); check("midwr_status", d, 8'h20);
    bus_read(3'd3, d); check("midwr_res_lo", d, 8'h8F);
    bus_read(3'd4, d); check("midwr_res_hi", d, 8'h00);
    bus_read(3'd0, d); check("midwr_a_kept", d, 8'h0D);

    // Reset during RUN, coincident with a bus write
    bus_write(3'd0, 8'hFF);
    bus_write(3'd1, 8'hFF);
    bus_write(3'd2, 8'h00);
    for (int i = 1; i <= 3; i++) bus_read(3'd2, d);
    check("pre_reset_do", rd_data, 8'h80);
    reset = 1'b1; cs = 1'b1; we = 1'b1; addr = 3'd0; di = 8'h77;
    @(negedge clk);
    reset = 1'b0; cs = 1'b0; we = 1'b0;
    check("midrst_do", rd_data, 8'h00);
    check("midrst_irq", {7'b0, irq}, 8'h00);
    bus_read(3'd2, d); check("midrst_status", d, 8'h00);
    bus_read(3'd3, d); check("midrst_res_lo", d, 8'h00);
    bus_read(3'd4, d); check("midrst_res_hi", d, 8'h00);
    bus_read(3'd0, d); check("midrst_a", d, 8'h00);
    repeat (10) @(negedge clk);
    check("midrst_idle_irq", {7'b0, irq}, 8'h00);
    run_op(vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/muldiv_6502.md
MULDIV_6502 -- requirements
Module: muldiv_6502

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port cs, input, 1, chip select from the 6502 bus decoder.
REQ-004 SHALL have port we, input, 1, write enable (1 = write, 0 = read), valid only with cs.
REQ-005 SHALL have port addr, input, 3, register select.
REQ-006 SHALL have port di, input, 8, write data from the CPU.
REQ-007 SHALL have port do, output, 8, registered read data to the CPU.
REQ-008 SHALL have port irq, output, 1, level interrupt request, active-high.

Function
REQ-009 SHALL implement this register map:
- 0: A (R/W)
- 1: B (R/W)
- 2: write CTRL / read STATUS
- 3: RES_LO (R)
- 4: RES_HI (R)
- 5-7: read 0x00, writes ignored.
REQ-010 CTRL write SHALL start an operation: di[0]=0 selects unsigned multiply A*B; di[0]=1 selects unsigned divide A/B. Other CTRL bits are ignored.
REQ-011 STATUS SHALL read as: bit7 busy, bit6 dz, bit5 done, bit0 op of the last started operation, other bits 0.
REQ-012 The FSM SHALL have states IDLE and RUN; a 3-bit iteration counter is active in RUN.
REQ-013 A CTRL write accepted at clock edge E0 SHALL enter RUN with busy=1; one iteration SHALL occur at each of edges E1..E8.
REQ-014 At E8 the block SHALL update RES_LO/RES_HI, clear busy, set done, and return to IDLE; results SHALL be readable from the cycle after E8.
REQ-015 Multiply SHALL use 8-step shift-add; RES_HI:RES_LO = 16-bit product.
REQ-016 Divide SHALL use 8-step restoring division; RES_LO = quotient, RES_HI = remainder.
REQ-017 When B=0, divide SHALL run the normal 8 steps, producing quotient 0xFF and remainder A, and SHALL set dz=1. dz SHALL be cleared at the start of every operation.
REQ-018 Operands SHALL be latched at E0; writes to A, B or CTRL while busy=1 SHALL be ignored, and RES_LO/RES_HI SHALL keep their previous values until E8.
REQ-019 Reads SHALL be registered: with cs=1 and we=0 at edge E, do SHALL hold the addressed value from E until the next read; do SHALL hold its value when not reading.
REQ-020 done SHALL be cleared by a STATUS read (cs=1, we=0, addr=2) or by a new start.
- If a STATUS read coincides with E8, the returned value SHALL show done=0 and busy=1, and done SHALL end the edge set.
REQ-021 A STATUS read while busy SHALL return busy=1, done=0, and SHALL have no other effect.

Reset
REQ-022 While reset=1 at a clock edge, the block SHALL clear A, B, RES_LO, RES_HI, do, busy, done, dz, op, the iteration counter and irq to 0, and the FSM SHALL go to IDLE.
REQ-023 Reset during RUN SHALL abort the operation with no result update; reset SHALL take priority over any simultaneous bus write.

Configuration
REQ-024 With macro MULDIV_IRQ_EN defined, irq SHALL equal done (registered, asserted from E8, cleared with done per REQ-020).
REQ-025 Without MULDIV_IRQ_EN, irq SHALL be constant 0 and no interrupt logic SHALL be built; all other behaviour SHALL be unchanged.

Verification
REQ-026 A=0x0D, B=0x0B, CTRL=0x00 -> busy for 8 cycles; then RES_LO=0x8F, RES_HI=0x00, STATUS=0x20.
REQ-027 A=0xFF, B=0xFF, multiply -> RES_HI:RES_LO=0xFE01; A=0xC8, B=0x07, CTRL=0x01 -> RES_LO=0x1C, RES_HI=0x04, STATUS=0x21.
REQ-028 A=0x55, B=0x00, divide -> RES_LO=0xFF, RES_HI=0x55, STATUS=0x61; the next start clears dz.
REQ-029 Mid-operation writes (A=0x99, then CTRL) at cycle 3 of RUN -> ignored; the result matches the original operands and A reads back the original value.
REQ-030 Reset asserted at cycle 4 of RUN -> STATUS=0x00, RES=0x0000, irq=0; a fresh operation afterwards completes correctly.
REQ-031 With MULDIV_IRQ_EN: irq rises at E8, stays high until a STATUS read, then falls; without the macro irq stays 0 throughout.
